// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter: entry format, idle tag and the
// round-robin pick function.
package cdb_pkg;

   localparam int unsigned TAG_W   = 4;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_SRC = 16;
   localparam int unsigned PICK_W  = 4;

   localparam logic [TAG_W-1:0] NULL_TAG = '1;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] result;
   } cdb_entry_t;

   typedef struct packed {
      logic              found;
      logic [PICK_W-1:0] idx;
   } rr_pick_t;

   // First requester at or after ptr, scanning upward modulo n.
   function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                        input int unsigned        n,
                                        input int unsigned        ptr);
      rr_pick_t    p;
      int unsigned s;
      p = '0;
      for (int unsigned off = 0; off < MAX_SRC; off++) begin
         if (off < n && !p.found) begin
            s = (ptr + off) % n;
            if (req[s]) begin
               p.found = 1'b1;
               p.idx   = PICK_W'(s);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; pointers wrap modulo DEPTH and occupancy is held in a separate count.
module cdb_fifo
   import cdb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  cdb_entry_t       din,
   output cdb_entry_t       dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   cdb_entry_t        mem [DEPTH];
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same cycle, so a push into a full FIFO is still taken.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers functional-unit results per source and broadcasts at most one per cycle on the CDB,
// granting non-empty sources round-robin.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter  int unsigned NUM_SRC = 2,
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned TAG_W   = cdb_pkg::TAG_W,
   parameter  int unsigned DATA_W  = cdb_pkg::DATA_W,
   localparam int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_result,
   output logic [NUM_SRC-1:0]        src_full,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_result,
   output logic [SRC_W-1:0]          cdb_src,
   output logic [NUM_SRC-1:0]        overflow
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   cdb_entry_t         fifo_dout  [NUM_SRC];
   logic [CNT_W-1:0]   fifo_count [NUM_SRC];
   logic [NUM_SRC-1:0] fifo_empty;
   logic [NUM_SRC-1:0] fifo_full;
   logic [NUM_SRC-1:0] push_req;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [MAX_SRC-1:0] req_vec;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   rr_next;
   rr_pick_t           pick;
   cdb_entry_t         gnt_entry;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      cdb_entry_t din;
      assign din.tag    = src_tag[i*TAG_W +: TAG_W];
      assign din.result = src_result[i*DATA_W +: DATA_W];

      // NULL_TAG pushes are discarded silently and never count as overflow.
      assign push_req[i] = src_valid[i] && (din.tag != NULL_TAG);
      assign push[i]     = push_req[i] && (!fifo_full[i] || pop[i]);
      // One slot held back for the result already in flight when the stall is seen.
      assign src_full[i] = (fifo_count[i] >= CNT_W'(DEPTH - 1));

      cdb_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (din),
         .dout  (fifo_dout[i]),
         .count (fifo_count[i]),
         .empty (fifo_empty[i]),
         .full  (fifo_full[i])
      );
   end

   always_comb begin
      req_vec                = '0;
      req_vec[NUM_SRC-1:0]   = ~fifo_empty;
   end

   assign pick = rr_pick(req_vec, NUM_SRC, 32'(rr_ptr));

   always_comb begin
      pop       = '0;
      gnt_entry = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (pick.found && (32'(pick.idx) == i)) begin
            pop[i]    = 1'b1;
            gnt_entry = fifo_dout[i];
         end
      end
   end

   always_comb begin
      rr_next = rr_ptr;
      if (pick.found) begin
         rr_next = (32'(pick.idx) == NUM_SRC - 1) ? '0 : SRC_W'(32'(pick.idx) + 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cdb_valid  <= 1'b0;
         cdb_tag    <= NULL_TAG;
         cdb_result <= '0;
         cdb_src    <= '0;
         rr_ptr     <= '0;
         overflow   <= '0;
      end else begin
         overflow <= overflow | (push_req & ~push);
         rr_ptr   <= rr_next;
         if (pick.found) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= gnt_entry.tag;
            cdb_result <= gnt_entry.result;
            cdb_src    <= SRC_W'(pick.idx);
         end else begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= NULL_TAG;
            cdb_result <= '0;
            cdb_src    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts broadcasts, stalls
// and overflow; a monitor compares the DUT every cycle.
module tb_cdb_arbiter;

   localparam int NS = 2;
   localparam int D  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  src_valid;
   logic [7:0]  src_tag;
   logic [63:0] src_result;
   logic [1:0]  src_full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_result;
   logic [0:0]  cdb_src;
   logic [1:0]  overflow;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_SRC (NS),
      .DEPTH   (D),
      .TAG_W   (4),
      .DATA_W  (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .src_valid  (src_valid),
      .src_tag    (src_tag),
      .src_result (src_result),
      .src_full   (src_full),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_result (cdb_result),
      .cdb_src    (cdb_src),
      .overflow   (overflow)
   );

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] res;
   } ent_t;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] res;
      int          src;
   } exp_t;

   ent_t       mq [NS][$];
   exp_t       exp_q[$];
   int         m_rr;
   logic [1:0] m_ovf;
   int         n_pass  = 0;
   int         n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) mq[i].delete();
      exp_q.delete();
      m_rr  = 0;
      m_ovf = '0;
   endtask

   // One clock edge of the reference: grant from the queues as they stood, then accept pushes.
   task automatic model_step();
      int   g;
      ent_t e;
      g = -1;
      for (int off = 0; off < NS; off++) begin
         if (g < 0 && mq[(m_rr + off) % NS].size() > 0) g = (m_rr + off) % NS;
      end
      if (g >= 0) begin
         e = mq[g].pop_front();
         exp_q.push_back('{tag: e.tag, res: e.res, src: g});
         m_rr = (g + 1) % NS;
      end
      for (int i = 0; i < NS; i++) begin
         if (src_valid[i] && src_tag[i*4 +: 4] != 4'hF) begin
            if (mq[i].size() < D) mq[i].push_back('{tag: src_tag[i*4 +: 4],
                                                    res: src_result[i*32 +: 32]});
            else m_ovf[i] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1);
      src_valid            = v;
      src_tag              = {t1, t0};
      src_result[31:0]     = $urandom();
      src_result[63:32]    = $urandom();
   endtask

   task automatic idle(input int n);
      src_valid = '0;
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic logic [3:0] rtag();
      return 4'($urandom_range(0, 14));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (cdb_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bcast", {63'd0, cdb_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, e.tag});
               chk("cdb_result", {32'd0, cdb_result}, {32'd0, e.res});
               chk("cdb_src", {63'd0, cdb_src}, 64'(e.src));
            end
         end else begin
            chk("missing_bcast", 64'(exp_q.size()), 64'd0);
            chk("idle_tag", {60'd0, cdb_tag}, 64'hF);
            chk("idle_result", {32'd0, cdb_result}, 64'd0);
            chk("idle_src", {63'd0, cdb_src}, 64'd0);
         end
         chk("overflow", {62'd0, overflow}, {62'd0, m_ovf});
         for (int i = 0; i < NS; i++) begin
            chk("src_full", {63'd0, src_full[i]}, {63'd0, mq[i].size() >= D - 1});
         end
      end
   end

   initial begin : driver
      src_valid  = '0;
      src_tag    = '0;
      src_result = '0;
      reset      = 1'b1;
      model_reset();
      #1;
      chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
      chk("rst_tag", {60'd0, cdb_tag}, 64'hF);
      chk("rst_full", {62'd0, src_full}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Single push: visible only after the second edge.
      drive(2'b01, 4'd3, 4'd0);
      src_result[31:0] = 32'h0000_0005;
      tick();
      src_valid = '0;
      chk("pre_e1_tag", {60'd0, cdb_tag}, 64'hF);
      chk("pre_e1_result", {32'd0, cdb_result}, 64'd0);
      tick();
      chk("e1_valid", {63'd0, cdb_valid}, 64'd1);
      chk("e1_tag", {60'd0, cdb_tag}, 64'd3);
      chk("e1_result", {32'd0, cdb_result}, 64'd5);
      idle(3);

      // Contention: both sources push every cycle.
      for (int k = 0; k < 8; k++) begin
         drive(2'b11, 4'(k), (k == 7) ? 4'd0 : 4'(8 + k));
         tick();
      end
      idle(12);

      // NULL_TAG pushes are dropped.
      for (int k = 0; k < 3; k++) begin
         drive(2'b01, 4'hF, 4'd0);
         tick();
      end
      idle(2);

      // Wrap-around through a single source.
      for (int k = 0; k < 10; k++) begin
         drive(2'b10, 4'd0, rtag());
         tick();
      end
      idle(4);

      // Fill both FIFOs under contention until they overflow.
      for (int k = 0; k < 14; k++) begin
         drive(2'b11, rtag(), rtag());
         tick();
      end
      chk("ovf_set", {62'd0, overflow}, 64'h3);
      idle(12);

      // Random traffic, occasional NULL_TAG.
      for (int k = 0; k < 300; k++) begin
         drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick();
      end

      // Reset between edges with entries queued.
      drive(2'b11, rtag(), rtag());
      tick();
      drive(2'b11, rtag(), rtag());
      tick();
      src_valid = '0;
      @(posedge clk);
      model_step();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_valid", {63'd0, cdb_valid}, 64'd0);
      chk("mid_rst_ovf", {62'd0, overflow}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(4);
      chk("post_rst_ovf", {62'd0, overflow}, 64'd0);

      for (int k = 0; k < 100; k++) begin
         drive(2'($urandom_range(0, 3)), rtag(), rtag());
         tick();
      end
      idle(12);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
